// File: rtl/encoder_emulator_mc.sv
// encoder_emulator_mc: multi-channel quadrature encoder emulator.
// Each channel produces an A/B quadrature pair from a programmable
// quarter-step divider and keeps a signed position count. Control and
// status go through a 64-bit AXI4-Lite slave.
module encoder_emulator_mc #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [NUM_CH-1:0]     encoder_a,
  output logic [NUM_CH-1:0]     encoder_b,
  output logic [NUM_CH-1:0]     done,
  input  logic [ADDR_WIDTH-1:0] CP_AWADDR,
  input  logic [2:0]            CP_AWPROT,
  input  logic                  CP_AWVALID,
  output logic                  CP_AWREADY,
  input  logic [63:0]           CP_WDATA,
  input  logic [7:0]            CP_WSTRB,
  input  logic                  CP_WVALID,
  output logic                  CP_WREADY,
  output logic [1:0]            CP_BRESP,
  output logic                  CP_BVALID,
  input  logic                  CP_BREADY,
  input  logic [ADDR_WIDTH-1:0] CP_ARADDR,
  input  logic [2:0]            CP_ARPROT,
  input  logic                  CP_ARVALID,
  output logic                  CP_ARREADY,
  output logic [63:0]           CP_RDATA,
  output logic [1:0]            CP_RRESP,
  output logic                  CP_RVALID,
  input  logic                  CP_RREADY
);

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [63:0] INFO_WORD   = {48'd0, 8'(NUM_CH), 8'(CNT_W)};

  // Protection bits carry no meaning for this block.
  logic unused_ok;
  assign unused_ok = ^{CP_AWPROT, CP_ARPROT};

  // Overlay the strobed bytes of a 64-bit write onto a CNT_W register value;
  // bits above CNT_W are dropped.
  function automatic logic [CNT_W-1:0] merge_bytes(input logic [CNT_W-1:0] old_val,
                                                   input logic [63:0] data,
                                                   input logic [7:0] strb);
    logic [63:0] word;
    word = 64'(old_val);
    for (int i = 0; i < 8; i++)
      if (strb[i]) word[i*8 +: 8] = data[i*8 +: 8];
    return word[CNT_W-1:0];
  endfunction

  // Address decode: channel in [7:5], register in [4:3], INFO at 0xF8.
  logic wr_fire, wr_ch_ok, wr_info;
  logic rd_fire, rd_ch_ok, rd_info;
  assign wr_fire  = CP_AWREADY && CP_AWVALID && CP_WVALID;
  assign wr_ch_ok = ((CP_AWADDR >> 8) == '0) && (32'(CP_AWADDR[7:5]) < NUM_CH);
  assign wr_info  = ((CP_AWADDR >> 8) == '0) && (CP_AWADDR[7:0] == 8'hF8);
  assign rd_fire  = CP_ARREADY && CP_ARVALID;
  assign rd_ch_ok = ((CP_ARADDR >> 8) == '0) && (32'(CP_ARADDR[7:5]) < NUM_CH);
  assign rd_info  = ((CP_ARADDR >> 8) == '0) && (CP_ARADDR[7:0] == 8'hF8);

  // Write channel: one-cycle AW/W ready pulse, response held until BREADY.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      CP_AWREADY <= 1'b0;
      CP_WREADY  <= 1'b0;
      CP_BVALID  <= 1'b0;
      CP_BRESP   <= RESP_OKAY;
    end else begin
      CP_AWREADY <= 1'b0;
      CP_WREADY  <= 1'b0;
      if (wr_fire) begin
        CP_BVALID <= 1'b1;
        CP_BRESP  <= (wr_ch_ok || wr_info) ? RESP_OKAY : RESP_SLVERR;
      end else if (CP_BVALID && CP_BREADY) begin
        CP_BVALID <= 1'b0;
      end else if (CP_AWVALID && CP_WVALID && !CP_BVALID && !CP_AWREADY) begin
        CP_AWREADY <= 1'b1;
        CP_WREADY  <= 1'b1;
      end
    end
  end

  // Per-channel read words are OR-combined; only the addressed one is nonzero.
  logic [63:0] rd_acc [NUM_CH+1];
  logic [63:0] rd_word;
  assign rd_acc[0] = '0;
  assign rd_word   = rd_acc[NUM_CH] | (rd_info ? INFO_WORD : 64'd0);

  // Read channel: one-cycle AR ready pulse, registered data held until RREADY.
  always_ff @(posedge clk) begin
    if (reset) begin
      CP_ARREADY <= 1'b0;
      CP_RVALID  <= 1'b0;
      CP_RDATA   <= '0;
      CP_RRESP   <= RESP_OKAY;
    end else begin
      CP_ARREADY <= 1'b0;
      if (rd_fire) begin
        CP_RVALID <= 1'b1;
        CP_RDATA  <= rd_word;
        CP_RRESP  <= (rd_ch_ok || rd_info) ? RESP_OKAY : RESP_SLVERR;
      end else if (CP_RVALID && CP_RREADY) begin
        CP_RVALID <= 1'b0;
      end else if (CP_ARVALID && !CP_RVALID && !CP_ARREADY) begin
        CP_ARREADY <= 1'b1;
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic             en, dir, mode, done_q, qa, qb;
    logic [CNT_W-1:0] period, steps, pos, div_cnt;
    logic             en_n, qa_n, qb_n, done_set;
    logic [CNT_W-1:0] steps_n, pos_n, div_n;
    logic             run, tc, wr_sel, rd_sel;
    logic [63:0]      rd_val;

    assign run    = en && (period != '0);
    // ">=" rather than "==" so a PERIOD shrunk below the count fires at once.
    assign tc     = run && (div_cnt >= period - CNT_W'(1));
    assign wr_sel = wr_fire && wr_ch_ok && (CP_AWADDR[7:5] == 3'(c));
    assign rd_sel = rd_ch_ok && (CP_ARADDR[7:5] == 3'(c));

    // Step engine: divider, quadrature advance, position and counted-mode stop.
    always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch behind.
      en_n     = en;
      steps_n  = steps;
      pos_n    = pos;
      div_n    = div_cnt;
      qa_n     = qa;
      qb_n     = qb;
      done_set = 1'b0;
      if (!run) begin
        div_n = '0;
      end else if (!tc) begin
        div_n = div_cnt + CNT_W'(1);
      end else begin
        div_n = '0;
        if (mode && steps == '0) begin
          en_n     = 1'b0;
          done_set = 1'b1;
        end else begin
          if (!dir) begin
            qa_n  = ~qb;
            qb_n  = qa;
            pos_n = pos + CNT_W'(1);
          end else begin
            qa_n  = qb;
            qb_n  = ~qa;
            pos_n = pos - CNT_W'(1);
          end
          if (mode) begin
            steps_n = steps - CNT_W'(1);
            if (steps == CNT_W'(1)) begin
              en_n     = 1'b0;
              done_set = 1'b1;
            end
          end
        end
      end
    end

    // Register update: engine result first, then a bus write overrides it.
    always_ff @(posedge clk) begin
      if (reset) begin
        en      <= 1'b0;
        dir     <= 1'b0;
        mode    <= 1'b0;
        done_q  <= 1'b0;
        qa      <= 1'b0;
        qb      <= 1'b0;
        period  <= '0;
        steps   <= '0;
        pos     <= '0;
        div_cnt <= '0;
      end else begin
        en      <= en_n;
        steps   <= steps_n;
        pos     <= pos_n;
        div_cnt <= div_n;
        qa      <= qa_n;
        qb      <= qb_n;
        done_q  <= done_q | done_set;
        if (wr_sel) begin
          case (CP_AWADDR[4:3])
            2'd0: if (CP_WSTRB[0]) begin
              en   <= CP_WDATA[0];
              dir  <= CP_WDATA[1];
              mode <= CP_WDATA[2];
              // A set on the same edge as the clear survives.
              if (CP_WDATA[3]) done_q <= done_set;
            end
            2'd1:    period <= merge_bytes(period, CP_WDATA, CP_WSTRB);
            2'd2:    steps  <= merge_bytes(steps_n, CP_WDATA, CP_WSTRB);
            default: pos    <= merge_bytes(pos_n, CP_WDATA, CP_WSTRB);
          endcase
        end
      end
    end

    // Read word for this channel; position is sign-extended to 64 bits.
    always_comb begin
      rd_val = '0;
      if (rd_sel) begin
        case (CP_ARADDR[4:3])
          2'd0:    rd_val = {60'd0, done_q, mode, dir, en};
          2'd1:    rd_val = 64'(period);
          2'd2:    rd_val = 64'(steps);
          default: rd_val = {{(64-CNT_W){pos[CNT_W-1]}}, pos};
        endcase
      end
    end

    assign rd_acc[c+1]  = rd_acc[c] | rd_val;
    assign encoder_a[c] = qa;
    assign encoder_b[c] = qb;
    assign done[c]      = done_q;
  end

endmodule

// File: tb/tb_encoder_emulator_mc.sv
// tb_encoder_emulator_mc: directed vectors with a response scoreboard for
// the multi-channel quadrature encoder emulator.
module tb_encoder_emulator_mc;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;
  localparam int AW     = 8;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic              clk = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] encoder_a, encoder_b, done;
  logic [AW-1:0]     CP_AWADDR, CP_ARADDR;
  logic [2:0]        CP_AWPROT, CP_ARPROT;
  logic              CP_AWVALID, CP_AWREADY, CP_WVALID, CP_WREADY;
  logic [63:0]       CP_WDATA, CP_RDATA;
  logic [7:0]        CP_WSTRB;
  logic [1:0]        CP_BRESP, CP_RRESP;
  logic              CP_BVALID, CP_BREADY, CP_ARVALID, CP_ARREADY;
  logic              CP_RVALID, CP_RREADY;

  always #5 clk = ~clk;

  encoder_emulator_mc #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .encoder_a(encoder_a), .encoder_b(encoder_b), .done(done),
    .CP_AWADDR(CP_AWADDR), .CP_AWPROT(CP_AWPROT), .CP_AWVALID(CP_AWVALID),
    .CP_AWREADY(CP_AWREADY), .CP_WDATA(CP_WDATA), .CP_WSTRB(CP_WSTRB),
    .CP_WVALID(CP_WVALID), .CP_WREADY(CP_WREADY), .CP_BRESP(CP_BRESP),
    .CP_BVALID(CP_BVALID), .CP_BREADY(CP_BREADY), .CP_ARADDR(CP_ARADDR),
    .CP_ARPROT(CP_ARPROT), .CP_ARVALID(CP_ARVALID), .CP_ARREADY(CP_ARREADY),
    .CP_RDATA(CP_RDATA), .CP_RRESP(CP_RRESP), .CP_RVALID(CP_RVALID),
    .CP_RREADY(CP_RREADY)
  );

  int total = 0;
  int bad   = 0;

  // Scoreboard queues: expected read and write responses, in issue order.
  logic [63:0] exp_rdata [$];
  logic [1:0]  exp_rresp [$];
  string       exp_rname [$];
  logic [1:0]  exp_bresp [$];
  string       exp_bname [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: handshake timeout, got no ready expected ready", name);
  endtask

  task automatic wr_start(input logic [7:0] addr, input logic [63:0] data, input logic [7:0] strb,
                          input logic [1:0] resp, input string name, input bit push);
    if (push) begin
      exp_bresp.push_back(resp);
      exp_bname.push_back(name);
    end
    CP_AWADDR  = addr;
    CP_WDATA   = data;
    CP_WSTRB   = strb;
    CP_AWVALID = 1'b1;
    CP_WVALID  = 1'b1;
  endtask

  task automatic wr_finish(input string name);
    int n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (CP_AWREADY) break;
      n++;
    end
    if (n == 50) timeout_fail(name);
    else begin
      @(posedge clk);
      #1;
    end
    CP_AWVALID = 1'b0;
    CP_WVALID  = 1'b0;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [63:0] data, input logic [7:0] strb,
                    input logic [1:0] resp, input string name);
    wr_start(addr, data, strb, resp, name, 1'b1);
    wr_finish(name);
  endtask

  task automatic rd_start(input logic [7:0] addr, input logic [63:0] data, input logic [1:0] resp,
                          input string name, input bit push);
    if (push) begin
      exp_rdata.push_back(data);
      exp_rresp.push_back(resp);
      exp_rname.push_back(name);
    end
    CP_ARADDR  = addr;
    CP_ARVALID = 1'b1;
  endtask

  task automatic rd_finish(input string name);
    int n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (CP_ARREADY) break;
      n++;
    end
    if (n == 50) timeout_fail(name);
    else begin
      @(posedge clk);
      #1;
    end
    CP_ARVALID = 1'b0;
  endtask

  task automatic rd(input logic [7:0] addr, input logic [63:0] data, input logic [1:0] resp,
                    input string name);
    rd_start(addr, data, resp, name, 1'b1);
    rd_finish(name);
  endtask

  // Monitor: compares each accepted R/B beat against the head of its queue.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (CP_RVALID && CP_RREADY) begin
        if (exp_rdata.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_r: got data 0x%0h expected no response", CP_RDATA);
        end else begin
          logic [63:0] d;
          logic [1:0]  r;
          string       n;
          d = exp_rdata.pop_front();
          r = exp_rresp.pop_front();
          n = exp_rname.pop_front();
          check({n, "_rdata"}, CP_RDATA, d);
          check({n, "_rresp"}, 64'(CP_RRESP), 64'(r));
        end
      end
      if (CP_BVALID && CP_BREADY) begin
        if (exp_bresp.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_b: got bresp %0d expected no response", CP_BRESP);
        end else begin
          logic [1:0] r;
          string      n;
          r = exp_bresp.pop_front();
          n = exp_bname.pop_front();
          check({n, "_bresp"}, 64'(CP_BRESP), 64'(r));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [1:0] exp_ab;
    reset      = 1'b1;
    CP_AWADDR  = '0;
    CP_ARADDR  = '0;
    CP_AWPROT  = '0;
    CP_ARPROT  = '0;
    CP_AWVALID = 1'b0;
    CP_WVALID  = 1'b0;
    CP_WDATA   = '0;
    CP_WSTRB   = '0;
    CP_ARVALID = 1'b0;
    CP_BREADY  = 1'b1;
    CP_RREADY  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_enc_a", 64'(encoder_a), 64'd0);
    check("rst_enc_b", 64'(encoder_b), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ready", 64'({CP_AWREADY, CP_WREADY, CP_ARREADY}), 64'd0);
    check("rst_valid", 64'({CP_BVALID, CP_RVALID}), 64'd0);
    reset = 1'b0;

    rd(8'hF8, 64'h0420, OKAY, "info");
    rd(8'h18, 64'd0, OKAY, "ch0_pos_rst");

    // ch0 free-run forward, PERIOD=3: A at 3, B at 6, A falls at 9, B falls at 12.
    wr(8'h08, 64'd3, 8'hFF, OKAY, "ch0_period");
    wr(8'h00, 64'h1, 8'h01, OKAY, "ch0_ctrl");
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (k < 3)       exp_ab = 2'b00;
      else if (k < 6)  exp_ab = 2'b10;
      else if (k < 9)  exp_ab = 2'b11;
      else if (k < 12) exp_ab = 2'b01;
      else             exp_ab = 2'b00;
      check($sformatf("ch0_ab_k%0d", k), 64'({encoder_a[0], encoder_b[0]}), 64'(exp_ab));
    end
    rd(8'h18, 64'd4, OKAY, "ch0_pos_4");

    // ch1 counted reverse: 5 steps every 2 clocks, then stop with DONE.
    wr(8'h28, 64'd2, 8'hFF, OKAY, "ch1_period");
    wr(8'h30, 64'd5, 8'hFF, OKAY, "ch1_steps");
    wr(8'h20, 64'h7, 8'h01, OKAY, "ch1_ctrl");
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (k < 2)       exp_ab = 2'b00;
      else if (k < 4)  exp_ab = 2'b01;
      else if (k < 6)  exp_ab = 2'b11;
      else if (k < 8)  exp_ab = 2'b10;
      else if (k < 10) exp_ab = 2'b00;
      else             exp_ab = 2'b01;
      check($sformatf("ch1_ab_k%0d", k), 64'({encoder_a[1], encoder_b[1]}), 64'(exp_ab));
      check($sformatf("ch1_done_k%0d", k), 64'(done[1]), (k >= 10) ? 64'd1 : 64'd0);
    end
    rd(8'h38, 64'hFFFF_FFFF_FFFF_FFFB, OKAY, "ch1_pos");
    rd(8'h30, 64'd0, OKAY, "ch1_steps_end");
    rd(8'h20, 64'hE, OKAY, "ch1_ctrl_end");
    wr(8'h20, 64'h8, 8'h01, OKAY, "ch1_w1c");
    check("ch1_done_clr", 64'(done[1]), 64'd0);
    rd(8'h20, 64'd0, OKAY, "ch1_ctrl_clr");

    // ch2 position wrap at the signed boundary, one counted forward step.
    wr(8'h58, 64'h7FFF_FFFF, 8'hFF, OKAY, "ch2_pos");
    wr(8'h48, 64'd4, 8'hFF, OKAY, "ch2_period");
    wr(8'h50, 64'd1, 8'hFF, OKAY, "ch2_steps");
    wr(8'h40, 64'h5, 8'h01, OKAY, "ch2_ctrl");
    repeat (6) @(posedge clk);
    #1;
    check("ch2_ab", 64'({encoder_a[2], encoder_b[2]}), 64'(2'b10));
    check("ch2_done", 64'(done[2]), 64'd1);
    rd(8'h58, 64'hFFFF_FFFF_8000_0000, OKAY, "ch2_pos_wrap");
    rd(8'h50, 64'd0, OKAY, "ch2_steps_end");
    rd(8'h40, 64'hC, OKAY, "ch2_ctrl_end");

    // ch3 counted with STEPS=0: no step, EN clears, DONE sets.
    wr(8'h68, 64'd2, 8'hFF, OKAY, "ch3_period");
    wr(8'h60, 64'h5, 8'h01, OKAY, "ch3_ctrl");
    repeat (3) @(posedge clk);
    #1;
    check("ch3_done", 64'(done[3]), 64'd1);
    check("ch3_ab", 64'({encoder_a[3], encoder_b[3]}), 64'd0);
    rd(8'h60, 64'hC, OKAY, "ch3_ctrl_end");
    rd(8'h78, 64'd0, OKAY, "ch3_pos");

    // Byte strobes and bits above CNT_W.
    wr(8'h68, 64'hAABB_CCDD, 8'h02, OKAY, "ch3_period_strb");
    rd(8'h68, 64'hCC02, OKAY, "ch3_period_strb");
    wr(8'h68, 64'hFFFF_FFFF_0000_0005, 8'hFF, OKAY, "ch3_period_wide");
    rd(8'h68, 64'd5, OKAY, "ch3_period_wide");

    // Unmapped channel 4.
    wr(8'h90, 64'h1234, 8'hFF, SLVERR, "unmapped_wr");
    rd(8'h90, 64'd0, SLVERR, "unmapped_rd");
    rd(8'h10, 64'd0, OKAY, "ch0_steps_kept");
    rd(8'h08, 64'd3, OKAY, "ch0_period_kept");

    // BREADY held low: BVALID stays, second write is not accepted.
    CP_BREADY = 1'b0;
    wr(8'h68, 64'd7, 8'hFF, OKAY, "bhold_first");
    wr_start(8'h68, 64'd9, 8'hFF, OKAY, "bhold_second", 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bhold_bvalid_%0d", i), 64'(CP_BVALID), 64'd1);
      check($sformatf("bhold_awready_%0d", i), 64'(CP_AWREADY), 64'd0);
    end
    @(posedge clk);
    #1;
    CP_BREADY = 1'b1;
    wr_finish("bhold_second");
    rd(8'h68, 64'd9, OKAY, "bhold_period");

    // Reset mid-run with ch0 still stepping and both responses pending.
    repeat (2) @(posedge clk);
    #1;
    CP_BREADY = 1'b0;
    CP_RREADY = 1'b0;
    wr_start(8'h10, 64'h55, 8'hFF, OKAY, "rst_wr", 1'b0);
    wr_finish("rst_wr");
    rd_start(8'h18, 64'd0, OKAY, "rst_rd", 1'b0);
    rd_finish("rst_rd");
    check("pre_rst_valid", 64'({CP_BVALID, CP_RVALID}), 64'(2'b11));
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_enc_a", 64'(encoder_a), 64'd0);
    check("midrst_enc_b", 64'(encoder_b), 64'd0);
    check("midrst_valid", 64'({CP_BVALID, CP_RVALID}), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    reset     = 1'b0;
    CP_BREADY = 1'b1;
    CP_RREADY = 1'b1;
    rd(8'h18, 64'd0, OKAY, "midrst_ch0_pos");
    rd(8'h00, 64'd0, OKAY, "midrst_ch0_ctrl");
    rd(8'h08, 64'd0, OKAY, "midrst_ch0_period");
    repeat (4) @(posedge clk);
    #1;
    check("midrst_enc_idle", 64'({encoder_a, encoder_b}), 64'd0);

    // Drain the scoreboard, bounded.
    for (int i = 0; i < 50; i++) begin
      if (exp_rdata.size() == 0 && exp_bresp.size() == 0) break;
      @(posedge clk);
    end
    check("r_queue_empty", 64'(exp_rdata.size()), 64'd0);
    check("b_queue_empty", 64'(exp_bresp.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
